// File: rtl/snd_i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module      : snd_i2s_tx
//  Description : Philips-format I2S transmitter for one stereo sample pair per
//                frame. All timing derives from the 384fs master clock:
//                  I2S_BCLK = SND_MCLK / 6   (64fs, 32-bit slots)
//                  I2S_LRCK = SND_MCLK / 384 (fs, 0 = left channel)
//                One sample pair can be parked in a holding register while the
//                current frame is on the wire. The pair moves into the frame
//                register once per frame. If no pair is waiting, a zero frame
//                is sent and UNDERRUN pulses for one cycle.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    SND_MCLK   in   1   master clock (384fs), the only clock of the block
//    RST        in   1   synchronous, active-high reset
//    S_LDATA    in   DW  left sample, two's complement
//    S_RDATA    in   DW  right sample, two's complement
//    S_VALID    in   1   sample pair valid
//    S_READY    out  1   holding register empty; a pair is taken on
//                        S_VALID && S_READY
//    MUTE       in   1   sampled at the frame load; high sends a zero frame
//    I2S_BCLK   out  1   bit clock
//    I2S_LRCK   out  1   word clock
//    I2S_SDATA  out  1   serial data, MSB first, one BCLK after LRCK changes
//    UNDERRUN   out  1   one-cycle pulse when a frame starts without a pair
// ============================================================================
module snd_i2s_tx #(
    parameter int DW = 24
) (
    input  logic          SND_MCLK,
    input  logic          RST,
    input  logic [DW-1:0] S_LDATA,
    input  logic [DW-1:0] S_RDATA,
    input  logic          S_VALID,
    output logic          S_READY,
    input  logic          MUTE,
    output logic          I2S_BCLK,
    output logic          I2S_LRCK,
    output logic          I2S_SDATA,
    output logic          UNDERRUN
);

    // Zero bits that follow the sample inside its 32-bit slot word. The slot
    // word is {delay bit, sample, padding}; the delay bit gives the I2S
    // one-BCLK offset between an LRCK change and the sample MSB.
    localparam int c_slot_pad = 31 - DW;

    localparam logic [2:0] c_div_last  = 3'd5;
    localparam logic [2:0] c_div_half  = 3'd3;
    localparam logic [5:0] c_bit_last  = 6'd63;
    localparam logic [5:0] c_bit_left  = 6'd0;
    localparam logic [5:0] c_bit_right = 6'd32;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [2:0]    div_cnt_q,  div_cnt_d;
    logic [5:0]    bit_cnt_q,  bit_cnt_d;

    logic          bclk_q,     bclk_d;
    logic          lrck_q,     lrck_d;
    logic          sdata_q,    sdata_d;
    logic          underrun_q, underrun_d;
    logic          ready_q,    ready_d;

    logic          flag_q,     flag_d;
    logic [DW-1:0] hold_l_q,   hold_l_d;
    logic [DW-1:0] hold_r_q,   hold_r_d;

    logic [DW-1:0] frame_l_q,  frame_l_d;
    logic [DW-1:0] frame_r_q,  frame_r_d;
    logic [31:0]   shift_q,    shift_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic          w_div_wrap;
    logic          w_bit_edge;
    logic          w_frame_load;
    logic          w_accept;
    logic [31:0]   w_left_word;
    logic [31:0]   w_right_word;
    logic [31:0]   w_slot_word;

    always_comb begin
        w_div_wrap   = (div_cnt_q == c_div_last);
        // div_cnt == 0 is the cycle whose registered result makes BCLK fall,
        // so LRCK and SDATA change together with the falling edge.
        w_bit_edge   = (div_cnt_q == 3'd0);
        w_frame_load = w_div_wrap && (bit_cnt_q == c_bit_last);
        // ready_q mirrors !flag_q outside reset, so at most one pair is taken
        // per frame and never while a pair is still waiting.
        w_accept     = S_VALID && ready_q;

        w_left_word  = 32'(frame_l_q) << c_slot_pad;
        w_right_word = 32'(frame_r_q) << c_slot_pad;

        // At the start of each half-frame the shifter is bypassed by the
        // freshly aligned slot word, so its MSB (the delay bit) goes out
        // straight away and the rest is shifted in behind it.
        if (bit_cnt_q == c_bit_left) begin
            w_slot_word = w_left_word;
        end else if (bit_cnt_q == c_bit_right) begin
            w_slot_word = w_right_word;
        end else begin
            w_slot_word = shift_q;
        end
    end

    // ------------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------------
    always_comb begin
        div_cnt_d = div_cnt_q + 3'd1;
        bit_cnt_d = bit_cnt_q;
        if (w_div_wrap) begin
            div_cnt_d = 3'd0;
            bit_cnt_d = bit_cnt_q + 6'd1;   // 63 wraps to 0 naturally
        end
    end

    // ------------------------------------------------------------------------
    // Serial outputs
    // ------------------------------------------------------------------------
    always_comb begin
        bclk_d  = (div_cnt_q >= c_div_half);
        lrck_d  = lrck_q;
        sdata_d = sdata_q;
        shift_d = shift_q;
        if (w_bit_edge) begin
            lrck_d  = bit_cnt_q[5];
            sdata_d = w_slot_word[31];
            shift_d = {w_slot_word[30:0], 1'b0};
        end
    end

    // ------------------------------------------------------------------------
    // Holding register, frame load and underrun
    // ------------------------------------------------------------------------
    always_comb begin
        flag_d     = flag_q;
        hold_l_d   = hold_l_q;
        hold_r_d   = hold_r_q;
        frame_l_d  = frame_l_q;
        frame_r_d  = frame_r_q;
        underrun_d = 1'b0;

        // The frame load is evaluated first. With a pair waiting no accept can
        // happen in the same cycle; with none waiting, an accept in the load
        // cycle lands in the holding register for the following frame.
        if (w_frame_load) begin
            flag_d     = 1'b0;
            underrun_d = !flag_q;
            if (flag_q && !MUTE) begin
                frame_l_d = hold_l_q;
                frame_r_d = hold_r_q;
            end else begin
                frame_l_d = '0;
                frame_r_d = '0;
            end
        end

        if (w_accept) begin
            flag_d   = 1'b1;
            hold_l_d = S_LDATA;
            hold_r_d = S_RDATA;
        end

        ready_d = !flag_d;
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge SND_MCLK) begin
        if (RST) begin
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            bclk_q     <= 1'b0;
            lrck_q     <= 1'b0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
            ready_q    <= 1'b0;
            flag_q     <= 1'b0;
            hold_l_q   <= '0;
            hold_r_q   <= '0;
            frame_l_q  <= '0;
            frame_r_q  <= '0;
            shift_q    <= '0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            bclk_q     <= bclk_d;
            lrck_q     <= lrck_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
            ready_q    <= ready_d;
            flag_q     <= flag_d;
            hold_l_q   <= hold_l_d;
            hold_r_q   <= hold_r_d;
            frame_l_q  <= frame_l_d;
            frame_r_q  <= frame_r_d;
            shift_q    <= shift_d;
        end
    end

    assign S_READY   = ready_q;
    assign I2S_BCLK  = bclk_q;
    assign I2S_LRCK  = lrck_q;
    assign I2S_SDATA = sdata_q;
    assign UNDERRUN  = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_snd_i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snd_i2s_tx
//  Description : Directed self-checking bench for snd_i2s_tx (DW = 24).
//                A monitor rebuilds each 64-slot frame from SDATA sampled at
//                BCLK rising edges, starting at every LRCK falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snd_i2s_tx;

    localparam int DW = 24;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic [DW-1:0] ldata = '0;
    logic [DW-1:0] rdata = '0;
    logic          valid = 1'b0;
    logic          mute  = 1'b0;
    logic          ready;
    logic          bclk;
    logic          lrck;
    logic          sdata;
    logic          underrun;

    always #5 clk = ~clk;

    snd_i2s_tx #(.DW(DW)) u_dut (
        .SND_MCLK  (clk),
        .RST       (rst),
        .S_LDATA   (ldata),
        .S_RDATA   (rdata),
        .S_VALID   (valid),
        .S_READY   (ready),
        .MUTE      (mute),
        .I2S_BCLK  (bclk),
        .I2S_LRCK  (lrck),
        .I2S_SDATA (sdata),
        .UNDERRUN  (underrun)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected frame: {delay bit, left, 7 pad, delay bit, right, 7 pad}.
    function automatic logic [63:0] mk_frame(input logic [23:0] l, input logic [23:0] r);
        return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
    endfunction

    // ------------------------------------------------------------------------
    // Cycle counter equals the DUT's position (bit_cnt*6 + div_cnt) mod 384
    // ------------------------------------------------------------------------
    int cyc = 0;
    int acc_cyc[$];
    always @(posedge clk) begin
        if (!rst && valid && ready) acc_cyc.push_back(cyc);
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // ------------------------------------------------------------------------
    // Frame / underrun monitor
    // ------------------------------------------------------------------------
    logic        prev_bclk = 1'b0;
    logic        prev_lrck = 1'b0;
    logic        prev_und  = 1'b0;
    logic        in_frame  = 1'b0;
    int          bit_idx   = 0;
    logic [63:0] acc       = '0;
    logic [63:0] frames[$];
    int          und_cnt   = 0;

    always @(negedge clk) begin
        if (bclk && !prev_bclk && in_frame) begin
            acc = {acc[62:0], sdata};
            bit_idx++;
            if (bit_idx == 64) begin
                frames.push_back(acc);
                in_frame = 1'b0;
            end
        end
        if (!lrck && prev_lrck) begin
            in_frame = 1'b1;
            bit_idx  = 0;
            acc      = '0;
        end
        if (underrun) begin
            und_cnt++;
            check_eq("und_width", {63'b0, prev_und}, 64'd0);
        end
        prev_bclk = bclk;
        prev_lrck = lrck;
        prev_und  = underrun;
    end

    task automatic clear_mon();
        in_frame = 1'b0;
        bit_idx  = 0;
        frames.delete();
        acc_cyc.delete();
        und_cnt  = 0;
    endtask

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    function automatic logic pick(input int sel);
        case (sel)
            0:       return bclk;
            1:       return lrck;
            2:       return underrun;
            default: return ready;
        endcase
    endfunction

    task automatic wait_level(input string tag, input int sel, input logic lvl, input int budget);
        int n = 0;
        while (pick(sel) !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (pick(sel) !== lvl) check_eq(tag, {63'b0, pick(sel)}, {63'b0, lvl});
    endtask

    task automatic wait_frames(input string tag, input int cnt, input int budget);
        int n = 0;
        while (frames.size() < cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (frames.size() < cnt) begin
            check_eq(tag, 64'(frames.size()), 64'(cnt));
            $display("FAIL %s: frames not captured, stopping", tag);
            $fatal(1);
        end
    endtask

    task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r);
        int n = 0;
        ldata = l;
        rdata = r;
        valid = 1'b1;
        while (!ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check_eq("t_send", 64'd0, 64'd1);
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        clear_mon();
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int t0;
        int n;
        int k;

        // ---- reset values and first cycle after reset -----------------------
        repeat (3) @(negedge clk);
        check_eq("rst_bclk",  {63'b0, bclk},     64'd0);
        check_eq("rst_lrck",  {63'b0, lrck},     64'd0);
        check_eq("rst_sdata", {63'b0, sdata},    64'd0);
        check_eq("rst_und",   {63'b0, underrun}, 64'd0);
        check_eq("rst_ready", {63'b0, ready},    64'd0);
        clear_mon();
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", {63'b0, ready}, 64'd1);

        // ---- free-run without data ------------------------------------------
        wait_level("t_und0", 2, 1'b1, 1000);
        t0 = cyc;
        @(negedge clk);
        check_eq("und_one_cycle", {63'b0, underrun}, 64'd0);
        wait_level("t_und1", 2, 1'b1, 1000);
        check_eq("und_period", 64'(cyc - t0), 64'd384);

        wait_level("t_bclk0", 0, 1'b0, 20);
        wait_level("t_bclk1", 0, 1'b1, 20);
        n = 0;
        while (bclk && n < 20) begin @(negedge clk); n++; end
        check_eq("bclk_high", 64'(n), 64'd3);
        n = 0;
        while (!bclk && n < 20) begin @(negedge clk); n++; end
        check_eq("bclk_low", 64'(n), 64'd3);

        wait_level("t_lr0", 1, 1'b0, 500);
        wait_level("t_lr1", 1, 1'b1, 500);
        t0 = cyc;
        wait_level("t_lr2", 1, 1'b0, 500);
        wait_level("t_lr3", 1, 1'b1, 500);
        check_eq("lrck_period", 64'(cyc - t0), 64'd384);

        wait_frames("t_idle_frames", 2, 1000);
        check_eq("idle_frame0", frames[0], 64'd0);
        check_eq("idle_frame1", frames[1], 64'd0);

        // ---- single pair before the first frame load ------------------------
        do_reset();
        send(24'hABCDEF, 24'h123456);
        check_eq("ready_low_held", {63'b0, ready}, 64'd0);
        wait_frames("t_data_frame", 1, 1000);
        check_eq("data_frame", frames[0], 64'h55E6F780_091A2B00);
        check_eq("data_no_und", 64'(und_cnt), 64'd0);

        // ---- continuous stream, 8 frames ------------------------------------
        do_reset();
        k     = 0;
        ldata = 24'h800001;
        rdata = 24'h7FFFFE;
        valid = 1'b1;
        n     = 0;
        while (k < 8 && n < 4000) begin
            if (ready) begin
                @(negedge clk);
                k++;
                ldata = 24'h800001 + 24'(k) * 24'h010203;
                rdata = 24'h7FFFFE - 24'(k) * 24'h000111;
                if (k == 8) valid = 1'b0;
            end else begin
                @(negedge clk);
            end
            n++;
        end
        valid = 1'b0;
        check_eq("stream_accepts", 64'(acc_cyc.size()), 64'd8);
        wait_frames("t_stream_frames", 8, 2000);
        for (int i = 2; i < 8; i++) begin
            if (i < acc_cyc.size())
                check_eq($sformatf("acc_interval%0d", i), 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd384);
        end
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("stream_frame%0d", i), frames[i],
                     mk_frame(24'h800001 + 24'(i) * 24'h010203, 24'h7FFFFE - 24'(i) * 24'h000111));
        end
        check_eq("stream_no_und", 64'(und_cnt), 64'd0);

        // ---- mute at the frame load with a pair held ------------------------
        do_reset();
        mute = 1'b1;
        send(24'h5A5A5A, 24'hA5A5A5);
        wait_level("t_mute_ready", 3, 1'b1, 1000);
        check_eq("mute_ready", {63'b0, ready}, 64'd1);
        check_eq("mute_und_now", {63'b0, underrun}, 64'd0);
        @(negedge clk);
        check_eq("mute_und_cnt", 64'(und_cnt), 64'd0);
        mute = 1'b0;
        send(24'h0F0F0F, 24'hF0F0F0);
        wait_frames("t_mute_frames", 2, 1500);
        check_eq("mute_frame", frames[0], 64'd0);
        check_eq("post_mute_frame", frames[1], mk_frame(24'h0F0F0F, 24'hF0F0F0));
        check_eq("post_mute_no_und", 64'(und_cnt), 64'd0);

        // ---- one-cycle reset at bit_cnt 40 with a pair held ----------------
        do_reset();
        send(24'h111111, 24'h222222);
        wait_level("t_abort_ready", 3, 1'b1, 1000);
        send(24'h333333, 24'h444444);
        n = 0;
        while (cyc < 384 + 40 * 6 && n < 1000) begin @(negedge clk); n++; end
        check_eq("pre_rst_lrck", {63'b0, lrck}, 64'd1);
        check_eq("pre_rst_held", {63'b0, ready}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_bclk",  {63'b0, bclk},     64'd0);
        check_eq("abort_lrck",  {63'b0, lrck},     64'd0);
        check_eq("abort_sdata", {63'b0, sdata},    64'd0);
        check_eq("abort_und",   {63'b0, underrun}, 64'd0);
        check_eq("abort_ready", {63'b0, ready},    64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort_ready_after", {63'b0, ready}, 64'd1);
        clear_mon();
        wait_frames("t_abort_frame", 1, 1000);
        check_eq("abort_frame", frames[0], 64'd0);
        check_eq("abort_und_cnt", 64'(und_cnt), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
